// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and PC field helpers for the branch predict unit.
package branch_predict_unit_pkg;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 30 - IDX_W;

  localparam logic [31:0] PC_INC = 32'd4;

  // 2-bit BHT states; only WT and ST predict taken.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [IDX_W-1:0] pc_idx(logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(logic [31:0] pc);
    return pc[31:IDX_W+2];
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup, EX-side resolution and statistics signals of the predictor.
interface branch_predict_unit_if;

  logic [31:0] cpc;
  logic        prediction;
  logic [31:0] control_pc;

  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred;
  logic [31:0] ex_pred_pc;
  logic        halt_happen;

  logic        flush;
  logic [31:0] pc_branch;
  logic [31:0] br_count;
  logic [31:0] mis_count;

  modport master (
    output cpc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred, ex_pred_pc,
           halt_happen,
    input  prediction, control_pc, flush, pc_branch, br_count, mis_count
  );

  modport slave (
    input  cpc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred, ex_pred_pc,
           halt_happen,
    output prediction, control_pc, flush, pc_branch, br_count, mis_count
  );

endinterface

// File: rtl/branch_predict_unit_sat_counter2.sv
// 2-bit saturating up/down counter with load and synchronous reset value.
module sat_counter2 #(
  parameter logic [1:0] ResetVal = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] cnt
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (load) begin
        cnt_d = load_val;
      end else if (up) begin
        if (cnt_q != 2'b11) cnt_d = cnt_q + 2'b01;
      end else begin
        if (cnt_q != 2'b00) cnt_d = cnt_q - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= ResetVal;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry 2-bit BHT: fetch lookup, EX resolution and training.
module branch_predict_unit (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_unit_if.slave bus
);
  import branch_predict_unit_pkg::*;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [1:0]         bht   [ENTRIES];
  logic [31:0]        br_q, br_d, mis_q, mis_d;

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  logic [IDX_W-1:0] rd_idx;
  logic             rd_hit;
  logic             pred;

  assign rd_idx = pc_idx(bus.cpc);
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == pc_tag(bus.cpc));
  assign pred   = rd_hit && bht[rd_idx][1];

  assign bus.prediction = pred;
  assign bus.control_pc = pred ? tgt_q[rd_idx] : bus.cpc + PC_INC;

  logic mis;
  logic live;

  assign live = bus.ex_valid && !rst;

  always_comb begin
    mis           = 1'b0;
    bus.flush     = 1'b0;
    bus.pc_branch = '0;
    if (bus.ex_is_branch) begin
      mis = (bus.ex_taken != bus.ex_pred) ||
            (bus.ex_taken && bus.ex_pred && (bus.ex_target != bus.ex_pred_pc));
    end else begin
      mis = bus.ex_pred;
    end
    if (live) begin
      bus.flush     = mis;
      bus.pc_branch = (bus.ex_is_branch && bus.ex_taken) ? bus.ex_target : bus.ex_pc + PC_INC;
    end
  end

  logic             train;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_hit;

  assign train  = bus.ex_valid && !bus.halt_happen && !rst;
  assign wr_idx = pc_idx(bus.ex_pc);
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == pc_tag(bus.ex_pc));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (train) begin
      if (bus.ex_is_branch && bus.ex_taken) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= pc_tag(bus.ex_pc);
        tgt_q[wr_idx]   <= bus.ex_target;
      end else if (!bus.ex_is_branch && bus.ex_pred) begin
        valid_q[wr_idx] <= 1'b0;
      end
    end
  end

  // A taken branch that misses the BTB starts its fresh entry at weak-taken.
  for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_bht
    sat_counter2 #(
      .ResetVal (WNT)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .en       (train && bus.ex_is_branch && (wr_idx == IDX_W'(g))),
      .up       (bus.ex_taken),
      .load     (bus.ex_taken && !wr_hit),
      .load_val (WT),
      .cnt      (bht[g])
    );
  end

  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (bus.ex_valid && !bus.halt_happen) begin
      if (bus.ex_is_branch && (br_q != '1)) br_d = br_q + 32'd1;
      if (mis && (mis_q != '1))             mis_d = mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

  assign bus.br_count  = br_q;
  assign bus.mis_count = mis_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed and randomized check of branch_predict_unit against a behavioural table model.
module tb_branch_predict_unit;

  logic clk;
  logic rst;

  branch_predict_unit_if bp_if ();

  branch_predict_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bp_if)
  );

  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_bht   [16];
  logic [31:0] m_br;
  logic [31:0] m_mis;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [25:0] tag_of(logic [31:0] pc);
    logic [31:0] t;
    t = pc / 64;
    return t[25:0];
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    return m_hit(pc) && (m_bht[idx_of(pc)] >= 2);
  endfunction

  function automatic bit m_mispredict();
    if (bp_if.ex_is_branch) begin
      if (bp_if.ex_taken != bp_if.ex_pred) return 1'b1;
      return bp_if.ex_taken && (bp_if.ex_target != bp_if.ex_pred_pc);
    end
    return bp_if.ex_pred;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_bht[i]   = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic model_update();
    int i;
    i = idx_of(bp_if.ex_pc);
    if (rst) begin
      model_reset();
    end else if (bp_if.ex_valid && !bp_if.halt_happen) begin
      if (bp_if.ex_is_branch) m_br = m_br + 1;
      if (m_mispredict()) m_mis = m_mis + 1;
      if (bp_if.ex_is_branch) begin
        if (bp_if.ex_taken) begin
          m_bht[i]   = m_hit(bp_if.ex_pc) ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3) : 2;
          m_valid[i] = 1'b1;
          m_tag[i]   = tag_of(bp_if.ex_pc);
          m_tgt[i]   = bp_if.ex_target;
        end else begin
          m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
        end
      end else if (bp_if.ex_pred) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic [31:0] c, input bit v, input bit br, input logic [31:0] pc,
                       input bit tk, input logic [31:0] tgt, input bit pr,
                       input logic [31:0] prpc, input bit h, input bit r);
    bp_if.cpc          = c;
    bp_if.ex_valid     = v;
    bp_if.ex_is_branch = br;
    bp_if.ex_pc        = pc;
    bp_if.ex_taken     = tk;
    bp_if.ex_target    = tgt;
    bp_if.ex_pred      = pr;
    bp_if.ex_pred_pc   = prpc;
    bp_if.halt_happen  = h;
    rst                = r;
  endtask

  // Checks all outputs against the model, then clocks once and advances the model.
  task automatic step();
    bit          ep;
    logic [31:0] ecpc;
    bit          ef;
    logic [31:0] epcb;
    #1;
    ep   = m_pred(bp_if.cpc);
    ecpc = ep ? m_tgt[idx_of(bp_if.cpc)] : bp_if.cpc + 32'd4;
    ef   = 1'b0;
    epcb = '0;
    if (bp_if.ex_valid && !rst) begin
      ef   = m_mispredict();
      epcb = (bp_if.ex_is_branch && bp_if.ex_taken) ? bp_if.ex_target : bp_if.ex_pc + 32'd4;
    end
    check32("prediction", {31'd0, bp_if.prediction}, {31'd0, ep});
    check32("control_pc", bp_if.control_pc, ecpc);
    check32("flush", {31'd0, bp_if.flush}, {31'd0, ef});
    check32("pc_branch", bp_if.pc_branch, epcb);
    check32("br_count", bp_if.br_count, m_br);
    check32("mis_count", bp_if.mis_count, m_mis);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  logic [31:0] pool_tgt [3];

  function automatic logic [31:0] rand_pc();
    logic [31:0] t;
    logic [31:0] i;
    t = (($urandom_range(0, 1) == 0) ? 32'd4 : 32'd5);
    i = 32'($urandom_range(0, 3));
    return (t << 6) | (i << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] saved_mis;
    logic [31:0] epc;
    bit          epr;
    n_assert    = 0;
    n_fail      = 0;
    pool_tgt[0] = 32'h40;
    pool_tgt[1] = 32'h80;
    pool_tgt[2] = 32'hC0;
    clk = 1'b0;
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state lookup
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check32("rst_control_pc", bp_if.control_pc, 32'h104);
    check32("rst_br_count", bp_if.br_count, 32'd0);
    step();

    // First taken resolution, predicted not-taken
    drive(32'h100, 1, 1, 32'h100, 1, 32'h40, 0, 0, 0, 0);
    #1 check32("alloc_flush", {31'd0, bp_if.flush}, 32'd1);
    check32("alloc_pc_branch", bp_if.pc_branch, 32'h40);
    step();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check32("alloc_lookup", bp_if.control_pc, 32'h40);
    check32("alloc_mis_count", bp_if.mis_count, 32'd1);
    step();

    // Not-taken twice: 10 -> 01 -> 00
    drive(32'h100, 1, 1, 32'h100, 0, 32'h40, 1, 32'h40, 0, 0);
    #1 check32("nt_pc_branch", bp_if.pc_branch, 32'h104);
    step();
    drive(32'h100, 1, 1, 32'h100, 0, 32'h40, 0, 0, 0, 0);
    #1 check32("nt_pred_off", {31'd0, bp_if.prediction}, 32'd0);
    check32("nt_no_flush", {31'd0, bp_if.flush}, 32'd0);
    step();

    // Retrain 00 -> 01 -> 10
    drive(32'h100, 1, 1, 32'h100, 1, 32'h40, 0, 0, 0, 0);
    step();
    drive(32'h100, 1, 1, 32'h100, 1, 32'h40, 0, 0, 0, 0);
    step();

    // Same index, different tag, must not hit
    drive(32'h140, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check32("alias_tag_pred", {31'd0, bp_if.prediction}, 32'd0);
    step();
    drive(32'h100, 1, 0, 32'h100, 0, 0, 1, 32'h40, 0, 0);
    #1 check32("alias_pred_before", {31'd0, bp_if.prediction}, 32'd1);
    check32("alias_pc_branch", bp_if.pc_branch, 32'h104);
    step();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check32("alias_invalid", {31'd0, bp_if.prediction}, 32'd0);
    step();

    // Correct direction, wrong target
    drive(32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h40, 0, 0);
    #1 check32("wrong_tgt_pc_branch", bp_if.pc_branch, 32'h80);
    step();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check32("wrong_tgt_update", bp_if.control_pc, 32'h80);
    step();

    // Halt freezes training but flush stays live
    saved_mis = bp_if.mis_count;
    drive(32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80, 1, 0);
    #1 check32("halt_flush", {31'd0, bp_if.flush}, 32'd1);
    step();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check32("halt_table", bp_if.control_pc, 32'h80);
    check32("halt_mis_count", bp_if.mis_count, saved_mis);
    step();

    // Reset with a valid resolution
    drive(32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 0, 0, 1);
    #1 check32("rst_ex_flush", {31'd0, bp_if.flush}, 32'd0);
    check32("rst_ex_pc_branch", bp_if.pc_branch, 32'd0);
    step();
    drive(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check32("rst_ex_cleared", bp_if.control_pc, 32'h104);
    step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      epc = rand_pc();
      epr = m_pred(epc);
      if ($urandom_range(0, 3) == 0) epr = 1'($urandom_range(0, 1));
      drive(rand_pc(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), epc,
            1'($urandom_range(0, 1)), pool_tgt[$urandom_range(0, 2)], epr,
            ((epr && m_hit(epc) && $urandom_range(0, 1) == 0) ? m_tgt[idx_of(epc)]
                                                              : pool_tgt[$urandom_range(0, 2)]),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
